// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate engine: one bit position per clock, valid/ready on both sides.
// Same 3-bit opcode set as the combinational shift unit, plus an explicit amount.
module shift_rotate_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // Handshake rule on both ports: a transfer happens on a rising edge where valid and
  // ready are both high; valid holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] next_work;

  function automatic logic [WIDTH-1:0] step1(input logic [2:0] o, input logic [WIDTH-1:0] v);
    case (o)
      3'b001, 3'b011: step1 = {v[WIDTH-2:0], 1'b0};
      3'b010:         step1 = {1'b0, v[WIDTH-1:1]};
      3'b100:         step1 = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b101:         step1 = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b110:         step1 = {v[0], v[WIDTH-1:1]};
      default:        step1 = v;
    endcase
  endfunction

  assign next_work = step1(op_q, work);
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      work      <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            // Pass, clear and zero-distance requests need no shifting steps.
            if (op == 3'b000 || op == 3'b111 || amount == '0) begin
              result    <= (op == 3'b111) ? '0 : data_in;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              work  <= data_in;
              count <= amount;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= next_work;
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            result    <= next_work;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
